// File: rtl/spi_master_driver.sv
// SPI mode-0 master: one MSB-first byte per start_i, SCLK half-period of CLK_DIV clocks.
// Every SPI pin and status output comes straight from a flop.
module spi_master_driver #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] data_in_bi,
   output logic       ready_o,
   output logic [7:0] data_out_bo,
   output logic       done_o,
   output logic       spi_sclk_o,
   output logic       spi_mosi_o,
   input  logic       spi_miso_i,
   output logic       spi_cs_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD
   } state_t;

   localparam logic [7:0] LP_RELOAD = 8'(CLK_DIV - 1);

   state_t     r_state, w_state;
   logic [7:0] r_cnt, w_cnt;
   logic [7:0] r_tx, w_tx;
   logic [7:0] r_rx, w_rx;
   logic [3:0] r_bit, w_bit;
   logic       r_sclk, w_sclk;
   logic       r_mosi, w_mosi;
   logic       r_cs, w_cs;
   logic       r_done, w_done;
   logic       r_ready, w_ready;
   logic [7:0] r_dout, w_dout;
   logic       w_phase_end;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_bit   <= '0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs    <= 1'b1;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
         r_dout  <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_tx    <= w_tx;
         r_rx    <= w_rx;
         r_bit   <= w_bit;
         r_sclk  <= w_sclk;
         r_mosi  <= w_mosi;
         r_cs    <= w_cs;
         r_done  <= w_done;
         r_ready <= w_ready;
         r_dout  <= w_dout;
      end
   end

   assign w_phase_end = (r_cnt == 8'd0);

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_tx    = r_tx;
      w_rx    = r_rx;
      w_bit   = r_bit;
      w_sclk  = r_sclk;
      w_mosi  = r_mosi;
      w_cs    = r_cs;
      w_done  = 1'b0;
      w_ready = r_ready;
      w_dout  = r_dout;
      // Every timed phase counts down; the branches below reload on a state change.
      if (r_state != S_IDLE && !w_phase_end) w_cnt = r_cnt - 8'd1;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_tx    = data_in_bi;
               w_rx    = '0;
               w_bit   = '0;
               w_cs    = 1'b0;
               w_mosi  = data_in_bi[7];
               w_ready = 1'b0;
               w_cnt   = LP_RELOAD;
               w_state = S_SETUP;
            end
         end
         S_SETUP, S_LOW: begin
            if (w_phase_end) begin
               w_sclk  = 1'b1;
               w_cnt   = LP_RELOAD;
               w_state = S_HIGH;
            end
         end
         S_HIGH: begin
            if (w_phase_end) begin
               w_rx   = {r_rx[6:0], spi_miso_i};
               w_sclk = 1'b0;
               w_bit  = r_bit + 4'd1;
               w_cnt  = LP_RELOAD;
               if (r_bit == 4'd7) begin
                  w_state = S_HOLD;
               end else begin
                  w_tx    = {r_tx[6:0], 1'b0};
                  w_mosi  = r_tx[6];
                  w_state = S_LOW;
               end
            end
         end
         S_HOLD: begin
            if (w_phase_end) begin
               w_cs    = 1'b1;
               w_mosi  = 1'b0;
               w_dout  = r_rx;
               w_done  = 1'b1;
               w_ready = 1'b1;
               w_cnt   = '0;
               w_state = S_IDLE;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end
      endcase
   end

   assign ready_o     = r_ready;
   assign data_out_bo = r_dout;
   assign done_o      = r_done;
   assign spi_sclk_o  = r_sclk;
   assign spi_mosi_o  = r_mosi;
   assign spi_cs_o    = r_cs;

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: CLK_DIV=4 instance for single transfers and reset abort,
// CLK_DIV=2 instance for back-to-back streaming with MISO tied high.
module tb_spi_master_driver;

   localparam int CD  = 4;
   localparam int CD2 = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, miso;
   logic [7:0] din;
   logic       ready, done, sclk, mosi, cs;
   logic [7:0] dout;
   logic       start2, miso2;
   logic [7:0] din2;
   logic       ready2, done2, sclk2, mosi2, cs2;
   logic [7:0] dout2;

   int         ncmp = 0;
   int         nfail = 0;
   logic [7:0] exp_dout = 8'h00;

   always #5 clk = ~clk;

   spi_master_driver #(.CLK_DIV(CD)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .data_in_bi(din),
      .ready_o(ready), .data_out_bo(dout), .done_o(done),
      .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_o(cs)
   );

   spi_master_driver #(.CLK_DIV(CD2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .data_in_bi(din2),
      .ready_o(ready2), .data_out_bo(dout2), .done_o(done2),
      .spi_sclk_o(sclk2), .spi_mosi_o(mosi2), .spi_miso_i(miso2), .spi_cs_o(cs2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transfer on u_dut; the slave is either a loopback or a mode-0 slave
   // that presents slv MSB-first, moving to the next bit after each SCLK fall.
   task automatic xfer(input logic [7:0] tx, input logic [7:0] slv,
                       input bit loop, input bit busy, input string tag);
      int nrise = 0, nfall = 0, cslow = 0, ndone = 0, viol = 0, done_at = -1;
      logic [7:0] cap = 8'h00;
      logic psclk = 1'b0, pmosi = 1'b0;
      chk({tag, "_hold"}, dout, exp_dout);
      chk({tag, "_ready"}, ready, 1);
      start = 1'b1;
      din   = tx;
      miso  = loop ? 1'b0 : slv[7];
      @(negedge clk);
      start = 1'b0;
      din   = 8'($urandom);
      for (int n = 0; n < 17 * CD + 40; n++) begin
         if (sclk && !psclk) begin
            nrise++;
            cap = {cap[6:0], mosi};
         end
         if (!sclk && psclk) nfall++;
         if (mosi !== pmosi && sclk !== 1'b0) viol++;
         if (!cs) cslow++;
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = n;
         end
         psclk = sclk;
         pmosi = mosi;
         miso  = loop ? mosi : (nfall < 8 ? slv[7 - nfall] : 1'b0);
         if (busy && n == 10) begin
            start = 1'b1;
            din   = 8'hFF;
         end else if (busy && n == 11) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      exp_dout = loop ? tx : slv;
      chk({tag, "_rises"}, nrise, 8);
      chk({tag, "_falls"}, nfall, 8);
      chk({tag, "_cs_low"}, cslow, 17 * CD);
      chk({tag, "_done_at"}, done_at, 17 * CD);
      chk({tag, "_ndone"}, ndone, 1);
      chk({tag, "_mosi_byte"}, cap, tx);
      chk({tag, "_mosi_stable"}, viol, 0);
      chk({tag, "_dout"}, dout, exp_dout);
      chk({tag, "_idle_cs"}, cs, 1);
   endtask

   initial begin
      int nrise, cslow, ndone, nlow, nhigh, runlen, seen_low;
      logic psclk, pcs;
      int lows[3];
      int highs[3];
      rst = 1'b1;  start = 1'b0;  din = 8'h00;  miso = 1'b0;
      start2 = 1'b0;  din2 = 8'h5A;  miso2 = 1'b1;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_cs", cs, 1);
      chk("rst2_state", {ready2, done2, dout2, sclk2, mosi2, cs2}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      xfer(8'hA5, 8'h00, 1'b1, 1'b0, "loopA5");
      xfer(8'hC3, 8'h3C, 1'b0, 1'b0, "slave3C");
      xfer(8'h12, 8'h81, 1'b0, 1'b1, "busy12");
      repeat (6) xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rnd");

      // Abort in the middle of the 4th bit's HIGH phase.
      start = 1'b1;  din = 8'h96;  miso = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nrise = 0;  ndone = 0;  psclk = 1'b0;
      for (int n = 0; n < 200 && nrise < 4; n++) begin
         if (sclk && !psclk) nrise++;
         if (done) ndone++;
         psclk = sclk;
         if (nrise < 4) @(negedge clk);
      end
      chk("abort_reached_bit4", nrise, 4);
      rst = 1'b1;
      #1;
      chk("abort_cs", cs, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_ready", ready, 1);
      chk("abort_dout", dout, 8'h00);
      chk("abort_mosi", mosi, 0);
      exp_dout = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      cslow = 0;
      for (int n = 0; n < 100; n++) begin
         if (done) ndone++;
         if (!cs) cslow++;
         @(negedge clk);
      end
      chk("abort_no_done", ndone, 0);
      chk("abort_no_resume", cslow, 0);
      xfer(8'h5C, 8'hE7, 1'b0, 1'b0, "post_abort");

      // Streaming on the CLK_DIV=2 instance with start held high.
      start2 = 1'b1;
      nlow = 0;  nhigh = 0;  runlen = 0;  seen_low = 0;  pcs = 1'b1;
      lows = '{0, 0, 0};
      highs = '{0, 0, 0};
      for (int n = 0; n < 4 * (17 * CD2 + 1) + 10; n++) begin
         @(negedge clk);
         if (done2) begin
            chk("b2b_done_dout", dout2, 8'hFF);
            chk("b2b_done_cs", cs2, 1);
         end
         if (cs2 !== pcs) begin
            if (pcs == 1'b0 && nlow < 3) lows[nlow++] = runlen;
            if (pcs == 1'b1 && seen_low != 0 && nhigh < 3) highs[nhigh++] = runlen;
            if (pcs == 1'b1) seen_low = 1;
            runlen = 0;
         end
         runlen++;
         pcs = cs2;
      end
      start2 = 1'b0;
      chk("b2b_nlow", nlow, 3);
      for (int i = 0; i < 3; i++) chk("b2b_cs_low", lows[i], 17 * CD2);
      for (int i = 0; i < 2; i++) chk("b2b_cs_high", highs[i], 1);
      repeat (60) @(negedge clk);
      chk("b2b_final_dout", dout2, 8'hFF);
      chk("b2b_final_ready", ready2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
